alu_share_arbiter: RTL and testbench

Shares the single registered ALU32Bit datapath between two requesters, for example the integer pipe and the address/branch-compare unit. The block performs round-robin issue arbitration and registers the ALU operands. It tracks in-flight operations with a tag pipeline matched to the ALU latency, then returns each result and a qualified overflow flag to the requester that issued it.

---
 rtl/alu_share_arbiter.sv | 169 ++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin issue arbiter sharing one registered ALU between two ports
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                drops every in-flight operation and blocks issue this cycle
//   reqN_valid/ready     per-port issue handshake (ready is combinational)
//   reqN_op/a/b/shamt    per-port ALU control code, operands, shift amount
//   alu_control/data1/data2/shamt   registered operands towards the ALU
//   alu_result/overflow  ALU outputs, valid LAT cycles after the operand edge
//   rspN_valid           one-cycle response strobe to the issuing port
//   rsp_result/overflow  shared response data; overflow only for add/sub
//   grant_cntN           saturating accepted-request counters
module alu_share_arbiter #(
  parameter int W    = 32,
  parameter int OPW  = 5,
  parameter int SHW  = 5,
  parameter int LAT  = 1,
  parameter logic [OPW-1:0] IDLE_OP = OPW'(5'h1F),
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OPW-1:0]  req0_op,
  input  logic [W-1:0]    req0_a,
  input  logic [W-1:0]    req0_b,
  input  logic [SHW-1:0]  req0_shamt,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OPW-1:0]  req1_op,
  input  logic [W-1:0]    req1_a,
  input  logic [W-1:0]    req1_b,
  input  logic [SHW-1:0]  req1_shamt,
  output logic [OPW-1:0]  alu_control,
  output logic [W-1:0]    alu_data1,
  output logic [W-1:0]    alu_data2,
  output logic [SHW-1:0]  alu_shamt,
  input  logic [W-1:0]    alu_result,
  input  logic            alu_overflow,
  output logic            rsp0_valid,
  output logic            rsp1_valid,
  output logic [W-1:0]    rsp_result,
  output logic            rsp_overflow,
  output logic [CNTW-1:0] grant_cnt0,
  output logic [CNTW-1:0] grant_cnt1
);

  // prio_ptr names the port that wins a tie; it flips to the loser after every grant.
  logic            prio_ptr;
  logic            grant0;
  logic            grant1;
  logic            accept;
  logic [OPW-1:0]  sel_op;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic [SHW-1:0]  sel_shamt;
  logic            sel_addsub;

  // Tag pipeline: one stage per cycle of ALU latency plus the operand register stage.
  logic [LAT:0]    tag_valid;
  logic [LAT:0]    tag_port;
  logic [LAT:0]    tag_addsub;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!flush) begin
      if (req0_valid && (!req1_valid || !prio_ptr)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign accept     = grant0 | grant1;
  // Gated by rst_n so nothing appears accepted while the block is held in reset.
  assign req0_ready = grant0 & rst_n;
  assign req1_ready = grant1 & rst_n;

  assign sel_op     = grant1 ? req1_op    : req0_op;
  assign sel_a      = grant1 ? req1_a     : req0_a;
  assign sel_b      = grant1 ? req1_b     : req0_b;
  assign sel_shamt  = grant1 ? req1_shamt : req0_shamt;
  // Only ADD (0) and SUB (1) produce a meaningful overflow flag.
  assign sel_addsub = (sel_op == OPW'(0)) || (sel_op == OPW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_ptr <= 1'b0;
    end else if (grant0) begin
      prio_ptr <= 1'b1;
    end else if (grant1) begin
      prio_ptr <= 1'b0;
    end
  end

  // Operand registers: data/shamt hold when idle, control drops to an unmatched
  // code so the ALU keeps its last result instead of recomputing stale operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_control <= IDLE_OP;
      alu_data1   <= '0;
      alu_data2   <= '0;
      alu_shamt   <= '0;
    end else if (accept) begin
      alu_control <= sel_op;
      alu_data1   <= sel_a;
      alu_data2   <= sel_b;
      alu_shamt   <= sel_shamt;
    end else begin
      alu_control <= IDLE_OP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid  <= '0;
      tag_port   <= '0;
      tag_addsub <= '0;
    end else begin
      tag_port   <= {tag_port[LAT-1:0], grant1};
      tag_addsub <= {tag_addsub[LAT-1:0], sel_addsub};
      if (flush) begin
        tag_valid <= '0;
      end else begin
        tag_valid <= {tag_valid[LAT-1:0], accept};
      end
    end
  end

  // The last tag stage lines up with the cycle in which alu_result is valid for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
    end else if (flush) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else if (tag_valid[LAT]) begin
      rsp0_valid   <= ~tag_port[LAT];
      rsp1_valid   <= tag_port[LAT];
      rsp_result   <= alu_result;
      rsp_overflow <= alu_overflow & tag_addsub[LAT];
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (grant0 && (grant_cnt0 != '1)) begin
        grant_cnt0 <= grant_cnt0 + CNTW'(1);
      end
      if (grant1 && (grant_cnt1 != '1)) begin
        grant_cnt1 <= grant_cnt1 + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter (LAT=1 and LAT=3/CNTW=4 instances)
module tb_alu_share_arbiter;

  localparam int LAT_A  = 1;
  localparam int CNTW_A = 16;
  localparam int LAT_B  = 3;
  localparam int CNTW_B = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [4:0]  req0_op = '0, req1_op = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [4:0]  req0_shamt = '0, req1_shamt = '0;
  logic        force_ovf = 1'b0;

  logic        a_req0_ready, a_req1_ready, b_req0_ready, b_req1_ready;
  logic [4:0]  a_alu_control, b_alu_control, a_alu_shamt, b_alu_shamt;
  logic [31:0] a_alu_data1, a_alu_data2, b_alu_data1, b_alu_data2;
  logic [31:0] a_alu_result, b_alu_result;
  logic        a_alu_overflow, b_alu_overflow;
  logic        a_rsp0_valid, a_rsp1_valid, b_rsp0_valid, b_rsp1_valid;
  logic [31:0] a_rsp_result, b_rsp_result;
  logic        a_rsp_overflow, b_rsp_overflow;
  logic [CNTW_A-1:0] a_grant_cnt0, a_grant_cnt1;
  logic [CNTW_B-1:0] b_grant_cnt0, b_grant_cnt1;

  always #5 clk = ~clk;

  alu_share_arbiter #(.LAT(LAT_A), .CNTW(CNTW_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(a_req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(a_req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_shamt(req1_shamt),
    .alu_control(a_alu_control), .alu_data1(a_alu_data1), .alu_data2(a_alu_data2),
    .alu_shamt(a_alu_shamt), .alu_result(a_alu_result), .alu_overflow(a_alu_overflow),
    .rsp0_valid(a_rsp0_valid), .rsp1_valid(a_rsp1_valid), .rsp_result(a_rsp_result),
    .rsp_overflow(a_rsp_overflow), .grant_cnt0(a_grant_cnt0), .grant_cnt1(a_grant_cnt1)
  );

  alu_share_arbiter #(.LAT(LAT_B), .CNTW(CNTW_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(b_req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(b_req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_shamt(req1_shamt),
    .alu_control(b_alu_control), .alu_data1(b_alu_data1), .alu_data2(b_alu_data2),
    .alu_shamt(b_alu_shamt), .alu_result(b_alu_result), .alu_overflow(b_alu_overflow),
    .rsp0_valid(b_rsp0_valid), .rsp1_valid(b_rsp1_valid), .rsp_result(b_rsp_result),
    .rsp_overflow(b_rsp_overflow), .grant_cnt0(b_grant_cnt0), .grant_cnt1(b_grant_cnt1)
  );

  // ALU behaviour: returns {matched, overflow, result}. 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHFT_L.
  function automatic logic [33:0] alu_f(input logic [4:0] op, input logic [31:0] x,
                                        input logic [31:0] y, input logic [4:0] sh);
    logic [31:0] r;
    logic o;
    logic m;
    r = '0; o = 1'b0; m = 1'b1;
    case (op)
      5'd0: begin r = x + y; o = (x[31] == y[31]) && (r[31] != x[31]); end
      5'd1: begin r = x - y; o = (x[31] != y[31]) && (r[31] != x[31]); end
      5'd2: r = x & y;
      5'd3: r = x | y;
      5'd4: r = y << sh;
      default: m = 1'b0;
    endcase
    return {m, o, r};
  endfunction

  // Registered ALU models with LAT_A / LAT_B cycles of latency; unmatched codes hold.
  logic [31:0] ra [0:LAT_A-1];
  logic        oa [0:LAT_A-1];
  logic [31:0] rb [0:LAT_B-1];
  logic        ob [0:LAT_B-1];

  initial begin
    for (int i = 0; i < LAT_A; i++) begin ra[i] = '0; oa[i] = 1'b0; end
    for (int i = 0; i < LAT_B; i++) begin rb[i] = '0; ob[i] = 1'b0; end
  end

  always @(posedge clk) begin : alu_model_a
    logic [33:0] f;
    f = alu_f(a_alu_control, a_alu_data1, a_alu_data2, a_alu_shamt);
    if (f[33]) begin ra[0] <= f[31:0]; oa[0] <= f[32]; end
    for (int i = 1; i < LAT_A; i++) begin ra[i] <= ra[i-1]; oa[i] <= oa[i-1]; end
  end

  always @(posedge clk) begin : alu_model_b
    logic [33:0] f;
    f = alu_f(b_alu_control, b_alu_data1, b_alu_data2, b_alu_shamt);
    if (f[33]) begin rb[0] <= f[31:0]; ob[0] <= f[32]; end
    for (int i = 1; i < LAT_B; i++) begin rb[i] <= rb[i-1]; ob[i] <= ob[i-1]; end
  end

  assign a_alu_result   = ra[LAT_A-1];
  assign a_alu_overflow = oa[LAT_A-1] | force_ovf;
  assign b_alu_result   = rb[LAT_B-1];
  assign b_alu_overflow = ob[LAT_B-1] | force_ovf;

  // Reference model: queue of outstanding responses with edges-to-go per DUT.
  typedef struct {
    int          dut;
    int          port;
    logic [31:0] res;
    logic        ovf;
    int          rem;
  } pend_t;

  pend_t       pq[$];
  logic        m_prio;
  int          m_cnt [2][2];
  logic        ex_v0 [2];
  logic        ex_v1 [2];
  logic [31:0] ex_res [2];
  logic        ex_ovf [2];
  int          lat_of [2];
  int          cmax [2];
  logic        cap_r0, cap_r1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pq.delete();
    m_prio = 1'b0;
    for (int d = 0; d < 2; d++) begin
      ex_v0[d] = 1'b0; ex_v1[d] = 1'b0; ex_res[d] = '0; ex_ovf[d] = 1'b0;
      m_cnt[d][0] = 0; m_cnt[d][1] = 0;
    end
  endtask

  // One clock cycle: drive, check combinational/registered outputs at negedge, advance model after the edge.
  task automatic step(input logic v0, input logic [4:0] o0, input logic [31:0] x0, input logic [31:0] y0,
                      input logic [4:0] s0, input logic v1, input logic [4:0] o1, input logic [31:0] x1,
                      input logic [31:0] y1, input logic [4:0] s1, input logic fl);
    logic g0, g1, acc;
    logic [4:0]  op, sh;
    logic [31:0] x, y;
    logic [33:0] f;
    pend_t e;
    req0_valid = v0; req0_op = o0; req0_a = x0; req0_b = y0; req0_shamt = s0;
    req1_valid = v1; req1_op = o1; req1_a = x1; req1_b = y1; req1_shamt = s1;
    flush = fl;
    g0 = !fl && v0 && (!v1 || (m_prio == 1'b0));
    g1 = !fl && v1 && !g0;
    acc = g0 || g1;
    op = g0 ? o0 : o1; x = g0 ? x0 : x1; y = g0 ? y0 : y1; sh = g0 ? s0 : s1;
    @(negedge clk);
    cap_r0 = a_req0_ready; cap_r1 = a_req1_ready;
    chk("a_ready0", a_req0_ready, g0);
    chk("a_ready1", a_req1_ready, g1);
    chk("b_ready0", b_req0_ready, g0);
    chk("b_ready1", b_req1_ready, g1);
    chk("a_rsp0_valid", a_rsp0_valid, ex_v0[0]);
    chk("a_rsp1_valid", a_rsp1_valid, ex_v1[0]);
    chk("a_rsp_result", a_rsp_result, ex_res[0]);
    chk("a_rsp_overflow", a_rsp_overflow, ex_ovf[0]);
    chk("b_rsp0_valid", b_rsp0_valid, ex_v0[1]);
    chk("b_rsp1_valid", b_rsp1_valid, ex_v1[1]);
    chk("b_rsp_result", b_rsp_result, ex_res[1]);
    chk("b_rsp_overflow", b_rsp_overflow, ex_ovf[1]);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin ex_v0[d] = 1'b0; ex_v1[d] = 1'b0; end
    if (fl) begin
      pq.delete();
    end else begin
      foreach (pq[i]) pq[i].rem = pq[i].rem - 1;
      for (int i = pq.size() - 1; i >= 0; i--) begin
        if (pq[i].rem == 0) begin
          if (pq[i].port == 0) ex_v0[pq[i].dut] = 1'b1;
          else ex_v1[pq[i].dut] = 1'b1;
          ex_res[pq[i].dut] = pq[i].res;
          ex_ovf[pq[i].dut] = pq[i].ovf;
          pq.delete(i);
        end
      end
      if (acc) begin
        f = alu_f(op, x, y, sh);
        for (int d = 0; d < 2; d++) begin
          e.dut = d;
          e.port = g0 ? 0 : 1;
          e.res = f[31:0];
          e.ovf = f[32] && ((op == 5'd0) || (op == 5'd1));
          e.rem = lat_of[d] + 1;
          pq.push_back(e);
          if (m_cnt[d][e.port] < cmax[d]) m_cnt[d][e.port]++;
        end
        m_prio = g0 ? 1'b1 : 1'b0;
      end
    end
    chk("a_alu_control", a_alu_control, acc ? op : 5'h1F);
    chk("b_alu_control", b_alu_control, acc ? op : 5'h1F);
    if (acc) begin
      chk("a_alu_data1", a_alu_data1, x);
      chk("a_alu_data2", a_alu_data2, y);
      chk("a_alu_shamt", a_alu_shamt, sh);
    end
    chk("a_cnt0", a_grant_cnt0, m_cnt[0][0]);
    chk("a_cnt1", a_grant_cnt1, m_cnt[0][1]);
    chk("b_cnt0", b_grant_cnt0, m_cnt[1][0]);
    chk("b_cnt1", b_grant_cnt1, m_cnt[1][1]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic issue(input int port, input logic [4:0] op, input logic [31:0] x,
                       input logic [31:0] y, input logic [4:0] sh);
    if (port == 0) step(1, op, x, y, sh, 0, 0, 0, 0, 0, 0);
    else           step(0, 0, 0, 0, 0, 1, op, x, y, sh, 0);
  endtask

  // Asserts rst_n mid-cycle with both requests valid and checks reset values immediately.
  task automatic do_reset();
    @(posedge clk);
    #1;
    req0_valid = 1'b1; req1_valid = 1'b1; flush = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_a_ready0", a_req0_ready, 0);
    chk("rst_a_ready1", a_req1_ready, 0);
    chk("rst_b_ready0", b_req0_ready, 0);
    chk("rst_a_alu_control", a_alu_control, 5'h1F);
    chk("rst_a_alu_data1", a_alu_data1, 0);
    chk("rst_a_alu_data2", a_alu_data2, 0);
    chk("rst_a_alu_shamt", a_alu_shamt, 0);
    chk("rst_a_rsp0_valid", a_rsp0_valid, 0);
    chk("rst_a_rsp1_valid", a_rsp1_valid, 0);
    chk("rst_b_rsp0_valid", b_rsp0_valid, 0);
    chk("rst_a_rsp_result", a_rsp_result, 0);
    chk("rst_a_rsp_overflow", a_rsp_overflow, 0);
    chk("rst_a_cnt0", a_grant_cnt0, 0);
    chk("rst_b_cnt0", b_grant_cnt0, 0);
    model_reset();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          port;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        ovf;
  } vec_t;

  vec_t vecs [9];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cnt;
    int lat_seen;
    logic got;
    lat_of[0] = LAT_A; lat_of[1] = LAT_B;
    cmax[0] = (1 << CNTW_A) - 1; cmax[1] = (1 << CNTW_B) - 1;
    vecs[0] = '{0, 5'd0, 32'd5,          32'd7,          5'd0,  32'd12,         1'b0};
    vecs[1] = '{1, 5'd0, 32'h7FFF_FFFF,  32'd1,          5'd0,  32'h8000_0000,  1'b1};
    vecs[2] = '{0, 5'd1, 32'd10,         32'd3,          5'd0,  32'd7,          1'b0};
    vecs[3] = '{1, 5'd1, 32'h8000_0000,  32'd1,          5'd0,  32'h7FFF_FFFF,  1'b1};
    vecs[4] = '{0, 5'd2, 32'hF0F0_F0F0,  32'hFF00_FF00,  5'd0,  32'hF000_F000,  1'b0};
    vecs[5] = '{1, 5'd3, 32'h0000_00F0,  32'h0000_000F,  5'd0,  32'h0000_00FF,  1'b0};
    vecs[6] = '{0, 5'd4, 32'd0,          32'd1,          5'd31, 32'h8000_0000,  1'b0};
    vecs[7] = '{1, 5'd0, 32'hFFFF_FFFF,  32'd1,          5'd0,  32'd0,          1'b0};
    vecs[8] = '{0, 5'd1, 32'd0,          32'h8000_0000,  5'd0,  32'h8000_0000,  1'b1};
    model_reset();
    do_reset();

    // Table: each op alone on its port, response checked LAT_A+1 edges after accept.
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh);
      if (i == 0) chk("first_cnt0", a_grant_cnt0, 1);
      idle(LAT_A + 1);
      chk("vec_rsp_valid", (vecs[i].port == 0) ? a_rsp0_valid : a_rsp1_valid, 1);
      chk("vec_rsp_other", (vecs[i].port == 0) ? a_rsp1_valid : a_rsp0_valid, 0);
      chk("vec_rsp_result", a_rsp_result, vecs[i].res);
      chk("vec_rsp_overflow", a_rsp_overflow, vecs[i].ovf);
      idle(LAT_B);
    end

    // Tie: both ports valid for 4 cycles right after reset -> grants 0,1,0,1.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 5'd1, 32'd10, 32'd3, 0, 1, 5'd3, 32'hF0, 32'h0F, 0, 0);
      chk("tie_grant0", cap_r0, (i % 2 == 0) ? 1 : 0);
      chk("tie_grant1", cap_r1, (i % 2 == 1) ? 1 : 0);
    end
    idle(LAT_B + 2);
    chk("tie_cnt0", a_grant_cnt0, 2);
    chk("tie_cnt1", a_grant_cnt1, 2);

    // Overflow qualification: SHFT_L never reports overflow even when the ALU flags it.
    force_ovf = 1'b1;
    issue(1, 5'd4, 32'd0, 32'd3, 5'd2);
    idle(LAT_A + 1);
    chk("shl_rsp1_valid", a_rsp1_valid, 1);
    chk("shl_result", a_rsp_result, 12);
    chk("shl_overflow", a_rsp_overflow, 0);
    idle(LAT_B + 1);
    force_ovf = 1'b0;
    idle(2);

    // Flush the cycle after the third back-to-back accept: LAT=3 instance never responds to them.
    issue(0, 5'd0, 32'd1, 32'd1, 0);
    issue(0, 5'd0, 32'd2, 32'd2, 0);
    issue(0, 5'd0, 32'd3, 32'd3, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      if (b_rsp0_valid) cnt++;
    end
    chk("flush_b_no_strobe", cnt, 0);
    issue(0, 5'd0, 32'd20, 32'd22, 0);
    lat_seen = 0;
    for (int k = 1; k <= 8; k++) begin
      idle(1);
      if (b_rsp0_valid && lat_seen == 0) lat_seen = k;
    end
    chk("lat3_latency", lat_seen, LAT_B + 1);
    chk("lat3_result", b_rsp_result, 42);

    // Reset with two ops in flight: no strobes afterwards, port 0 wins the next tie.
    issue(0, 5'd0, 32'd4, 32'd4, 0);
    issue(1, 5'd3, 32'd4, 32'd1, 0);
    do_reset();
    got = 1'b0;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      got = got | a_rsp0_valid | a_rsp1_valid | b_rsp0_valid | b_rsp1_valid;
    end
    chk("post_reset_no_strobe", got, 0);
    step(1, 5'd2, 32'hFF, 32'h0F, 0, 1, 5'd2, 32'h1, 32'h1, 0, 0);
    chk("post_reset_tie_port0", cap_r0, 1);
    idle(LAT_B + 2);

    // Counter saturation on the CNTW=4 instance.
    do_reset();
    for (int i = 0; i < 19; i++) begin
      issue(0, 5'd2, i, 32'hFFFF_FFFF, 0);
      if (i == 14) chk("cnt_at_15", b_grant_cnt0, 15);
    end
    chk("cnt_saturated", b_grant_cnt0, 15);
    chk("cnt_wide", a_grant_cnt0, 19);
    idle(LAT_B + 2);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1), 5'($urandom_range(0, 4)), $urandom, $urandom, 5'($urandom_range(0, 31)),
           $urandom_range(0, 1), 5'($urandom_range(0, 4)), $urandom, $urandom, 5'($urandom_range(0, 31)),
           ($urandom_range(0, 15) == 0));
    end
    idle(LAT_B + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
